cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling responder for the cores' instruction and data caches. On a cache miss it takes ownership of the main-memory read port, issues one word read per cycle for every word of the missing block, writes each returned word into the cache data array, and finally writes the tag. While working it holds `fsm_busy` high; the core's hazard unit uses that signal to stall the pipeline. One instance serves the I-cache (`i_fsm_busy`) and one serves the D-cache (`d_fsm_busy`).

## Interface
- `BLOCK_WORDS`, 8: 16-bit words per cache block; power of two, ≥2.
- `ADDR_W`, 16: byte-address width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `miss_detected`  in  1  cache lookup missed this cycle; level, held by the cache until the fill completes.
- `miss_address`  in  ADDR_W  byte address of the missing access; only sampled in IDLE.
- `mem_data_valid`  in  1  main memory is returning one read word this cycle.
- `mem_data`  in  16  returned word; valid only when `mem_data_valid` is high.
- `fsm_busy`  out  1  fill in progress; stall request to the hazard unit.
- `mem_rd_en`  out  1  read request to main memory this cycle.
- `mem_addr`  out  ADDR_W  byte address of the current read request.
- `data_wren`  out  1  write one word into the cache data array.
- `data_word`  out  log2(BLOCK_WORDS)  word index within the block for `data_wren`.
- `data_out`  out  16  word to write; equals `mem_data`.
- `tag_wren`  out  1  write the tag and valid bit for the filled block.
- `fill_addr`  out  ADDR_W  block-aligned base address of the current fill; the cache takes the tag from it.

## Operation
- States: IDLE, FILL.
- Registers:
  - `base`: latched block base address.
  - `issue_cnt`: 0..BLOCK_WORDS.
  - `recv_cnt`: 0..BLOCK_WORDS-1.
- IDLE, `miss_detected`=1 at a clock edge:
  - `base` ← `miss_address` with the low log2(2·BLOCK_WORDS) bits cleared.
  - Both counters ← 0.
  - Next state is FILL.
- IDLE, otherwise: stay in IDLE. `mem_data_valid` is ignored and produces no writes.
- FILL, request issue:
  - `mem_rd_en` = (`issue_cnt` < BLOCK_WORDS).
  - `mem_addr` = `base` + 2·`issue_cnt`, with `issue_cnt` truncated to log2(BLOCK_WORDS) bits. No carry past the block boundary.
  - `issue_cnt` increments on every cycle in which `mem_rd_en` is high, then saturates at BLOCK_WORDS.
- FILL, data return:
  - `data_wren` = `mem_data_valid`, `data_word` = `recv_cnt`, `data_out` = `mem_data`; combinational, same cycle.
  - `recv_cnt` increments on each valid word.
- FILL, completion: when `mem_data_valid` arrives with `recv_cnt` = BLOCK_WORDS-1:
  - `tag_wren` = 1 in that same cycle.
  - Next state is IDLE.
- Words fill in ascending order from the block base, not critical-word-first.
- `miss_detected` and `miss_address` are ignored while in FILL.
- `miss_detected` still high in IDLE right after a completion starts a new fill. The cache must drop it once the tag is valid.
- `fsm_busy` = (state == FILL).
- `fill_addr` = `base`.
- Reset (asynchronous, any time, including mid-fill):
  - State goes to IDLE; counters and `base` clear to 0.
  - All outputs are 0 during and immediately after reset.
  - A partially written block is left with no tag write, so it remains invalid.

## Timing
- The FSM has no memory-latency parameter; completion is counted purely by `mem_data_valid` pulses.
- Edge N samples `miss_detected`=1 in IDLE. `fsm_busy` and `mem_rd_en` rise after edge N.
- Requests occupy BLOCK_WORDS consecutive cycles starting the cycle after edge N.
- With a memory of fixed latency L (first data L cycles after the first request):
  - `fsm_busy` is high for BLOCK_WORDS+L cycles.
  - `tag_wren` pulses in the final busy cycle.
  - `fsm_busy` falls at the next edge.
- A valid word may coincide with an issue cycle; both proceed in the same cycle.
- The earliest new miss is accepted at the edge immediately after `fsm_busy` falls.

## Test plan
- **Basic fill.** Reset, then `miss_address`=0x1236 for one cycle; memory latency 4.
  - `mem_addr` runs 0x1230,0x1232,…,0x123E over 8 cycles.
  - `data_word` 0..7 with the matching data.
  - One `tag_wren` pulse with `fill_addr`=0x1230.
  - `fsm_busy` high for exactly 12 cycles.
- **Block-end address, no carry.** `miss_address`=0xFFFE.
  - Base is 0xFFF0.
  - Last `mem_addr` is 0xFFFE, with no wrap to 0x0000 inside the block.
- **Miss ignored in FILL.** Pulse a new miss with address 0x4000 mid-fill.
  - The fill continues with the original base; no address 0x4000 appears.
  - A miss still asserted after completion starts a new fill at the next edge.
- **Irregular returns.** Return `mem_data_valid` with random gaps, 8 pulses total.
  - Exactly 8 `data_wren` with `data_word` in order.
  - `tag_wren` only with the 8th pulse.
- **Spurious valid.** Drive `mem_data_valid` high while in IDLE.
  - No `data_wren`, no `tag_wren`; `fsm_busy` stays 0.
- **Reset mid-fill.** Assert `rst_n`=0 after 3 returned words.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - No `tag_wren` occurs.
  - After reset, a new miss at 0x0020 completes a normal fill.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: owns the memory read port for one block fill, streams returned
// words into the cache data array in ascending order, then writes the tag.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           mem_data_valid,
    input  logic [15:0]                    mem_data,
    output logic                           fsm_busy,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           data_wren,
    output logic [$clog2(BLOCK_WORDS)-1:0] data_word,
    output logic [15:0]                    data_out,
    output logic                           tag_wren,
    output logic [ADDR_W-1:0]              fill_addr
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);

    // Clears the word index and byte-offset bits of a byte address.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-IDX_W-1){1'b1}}, {(IDX_W+1){1'b0}}};

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t             stateQ;
    state_t             stateD;
    logic [ADDR_W-1:0]  base;
    logic [IDX_W:0]     issueCnt;
    logic [IDX_W-1:0]   recvCnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // NOTE: only control/address registers exist here, so all of them take the async reset;
    // the block data itself lives in the cache array and needs no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            issueCnt <= '0;
            recvCnt  <= '0;
        end else if (stateQ == IDLE) begin
            if (miss_detected) begin
                base     <= miss_address & ALIGN_MASK;
                issueCnt <= '0;
                recvCnt  <= '0;
            end
        end else begin
            if (mem_rd_en) begin
                issueCnt <= issueCnt + (IDX_W+1)'(1);
            end
            if (mem_data_valid) begin
                recvCnt <= recvCnt + IDX_W'(1);
            end
        end
    end

    // NOTE: every output and next-state value gets a default before the case, so no
    // path through this block can infer a latch.
    always_comb begin
        stateD    = stateQ;
        fsm_busy  = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        data_wren = 1'b0;
        data_out  = '0;
        tag_wren  = 1'b0;

        unique case (stateQ)
            IDLE: begin
                if (miss_detected) begin
                    stateD = FILL;
                end
            end
            FILL: begin
                fsm_busy  = 1'b1;
                // BLOCK_WORDS is a power of two: the counter MSB marks saturation.
                mem_rd_en = !issueCnt[IDX_W];
                // Base is block-aligned, so OR-ing the word offset cannot carry out of the block.
                mem_addr  = base | {{(ADDR_W-IDX_W-1){1'b0}}, issueCnt[IDX_W-1:0], 1'b0};
                data_wren = mem_data_valid;
                data_out  = mem_data;
                if (mem_data_valid && (&recvCnt)) begin
                    tag_wren = 1'b1;
                    stateD   = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign data_word = recvCnt;
    assign fill_addr = base;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a memory model answers reads with an address hash,
// expected requests/writes/tag/busy lengths are queued by stimulus and popped by a monitor.
module tb_cache_fill_fsm;

    localparam int BW = 8;
    localparam int AW = 16;
    localparam int IW = $clog2(BW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          missDetected = 1'b0;
    logic [AW-1:0] missAddress = '0;
    logic          memDataValid = 1'b0;
    logic [15:0]   memData = '0;

    logic          fsmBusy;
    logic          memRdEn;
    logic [AW-1:0] memAddr;
    logic          dataWren;
    logic [IW-1:0] dataWord;
    logic [15:0]   dataOut;
    logic          tagWren;
    logic [AW-1:0] fillAddr;

    cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_detected  (missDetected),
        .miss_address   (missAddress),
        .mem_data_valid (memDataValid),
        .mem_data       (memData),
        .fsm_busy       (fsmBusy),
        .mem_rd_en      (memRdEn),
        .mem_addr       (memAddr),
        .data_wren      (dataWren),
        .data_word      (dataWord),
        .data_out       (dataOut),
        .tag_wren       (tagWren),
        .fill_addr      (fillAddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [15:0]   data;
        bit            last;
        logic [AW-1:0] base;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            readyCyc;
    } pend_t;

    logic [AW-1:0] expReqQ[$];
    wr_t           expWrQ[$];
    int            expBusyQ[$];
    pend_t         pendQ[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int memLat = 4;
    int wrCount = 0;
    int tagCount = 0;
    int busyRun = 0;
    bit gapMode = 1'b0;
    bit spurious = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] memWord(input logic [AW-1:0] a);
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [63:0] allOutputs();
        return 64'({fsmBusy, memRdEn, memAddr, dataWren, dataWord, dataOut, tagWren, fillAddr});
    endfunction

    // Reference model: a fill reads the aligned block word by word, ascending.
    task automatic expectFill(input logic [AW-1:0] addr, input int busyExp);
        logic [AW-1:0] b;
        b = addr & ~AW'(2 * BW - 1);
        for (int i = 0; i < BW; i++) begin
            expReqQ.push_back(b + AW'(2 * i));
            expWrQ.push_back('{idx: i, data: memWord(b + AW'(2 * i)), last: (i == BW - 1), base: b});
        end
        expBusyQ.push_back(busyExp);
    endtask

    // Called at posedge+1 with the DUT idle; the miss is presented for exactly one edge.
    task automatic issueMiss(input logic [AW-1:0] addr, input int busyExp);
        expectFill(addr, busyExp);
        missAddress  = addr;
        missDetected = 1'b1;
        @(posedge clk);
        #1;
        missDetected = 1'b0;
        missAddress  = AW'($urandom);
    endtask

    task automatic waitDone(input int budget, input string name);
        int n = 0;
        while ((expWrQ.size() != 0 || expReqQ.size() != 0 || fsmBusy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " completion within budget"}, 64'(n < budget), 64'd1);
    endtask

    // Memory model: one word per cycle once its latency has elapsed, optional random gaps.
    pend_t memP;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                memDataValid = 1'b0;
            end else if (spurious) begin
                memDataValid = 1'($urandom);
                memData      = 16'($urandom);
            end else if (pendQ.size() != 0 && pendQ[0].readyCyc <= cyc &&
                         (!gapMode || $urandom_range(0, 2) == 0)) begin
                memP         = pendQ.pop_front();
                memDataValid = 1'b1;
                memData      = memWord(memP.addr);
            end else begin
                memDataValid = 1'b0;
                memData      = 16'($urandom);
            end
        end
    end

    // Monitor: compares every DUT transaction against the queued expectations.
    logic [AW-1:0] monA;
    wr_t           monW;
    int            monB;
    always @(negedge clk) begin
        if (!rst_n) begin
            busyRun = 0;
        end else begin
            if (tagWren) tagCount++;
            if (memRdEn) begin
                if (expReqQ.size() == 0) begin
                    check("unexpected mem_rd_en", 64'(memRdEn), 64'd0);
                end else begin
                    monA = expReqQ.pop_front();
                    check("mem_addr", 64'(memAddr), 64'(monA));
                end
                pendQ.push_back('{addr: memAddr, readyCyc: cyc + memLat});
            end
            if (dataWren) begin
                if (expWrQ.size() == 0) begin
                    check("unexpected data_wren", 64'(dataWren), 64'd0);
                end else begin
                    monW = expWrQ.pop_front();
                    wrCount++;
                    check("data_word", 64'(dataWord), 64'(monW.idx));
                    check("data_out", 64'(dataOut), 64'(monW.data));
                    check("tag_wren on write", 64'(tagWren), 64'(monW.last));
                    if (monW.last) check("fill_addr at tag", 64'(fillAddr), 64'(monW.base));
                end
            end else if (tagWren) begin
                check("tag_wren without data_wren", 64'(tagWren), 64'd0);
            end
            if (fsmBusy) begin
                busyRun++;
            end else if (busyRun > 0) begin
                if (expBusyQ.size() == 0) begin
                    check("unexpected busy period", 64'(busyRun), 64'd0);
                end else begin
                    monB = expBusyQ.pop_front();
                    if (monB >= 0) check("busy cycles", 64'(busyRun), 64'(monB));
                end
                busyRun = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int w0;

        // Reset state
        #2;
        check("outputs during reset", allOutputs(), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("outputs after reset", allOutputs(), 64'd0);
        @(posedge clk);
        #1;

        // Basic fill, latency 4: 12 busy cycles
        memLat = 4;
        issueMiss(16'h1236, BW + 4);
        waitDone(100, "basic");

        // Block at the top of the address space
        issueMiss(16'hFFFE, BW + 4);
        waitDone(100, "block end");

        // New miss mid-fill is ignored
        memLat = 3;
        issueMiss(16'h5678, BW + 3);
        repeat (3) begin @(posedge clk); #1; end
        missAddress  = 16'h4000;
        missDetected = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        missDetected = 1'b0;
        waitDone(100, "miss in fill");

        // Miss held through completion starts a second fill one cycle after busy falls
        expectFill(16'h0A16, BW + 3);
        expectFill(16'h0A16, BW + 3);
        missAddress  = 16'h0A16;
        missDetected = 1'b1;
        t0 = tagCount;
        n = 0;
        while (tagCount == t0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("first tag of held miss", 64'(n < 100), 64'd1);
        #1;
        check("busy drops after tag", 64'(fsmBusy), 64'd0);
        @(posedge clk);
        #1;
        check("held miss restarts fill", 64'(fsmBusy), 64'd1);
        missDetected = 1'b0;
        waitDone(100, "held miss");

        // Irregular returns with random gaps
        gapMode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            memLat = $urandom_range(1, 5);
            issueMiss(AW'($urandom), -1);
            waitDone(400, "irregular");
        end
        gapMode = 1'b0;

        // Random addresses, fixed random latency
        for (int k = 0; k < 4; k++) begin
            memLat = $urandom_range(1, 6);
            issueMiss(AW'($urandom), BW + memLat);
            waitDone(100, "random fill");
        end

        // Spurious valid while idle
        t0 = tagCount;
        w0 = wrCount;
        spurious = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("idle busy under spurious valid", 64'(fsmBusy), 64'd0);
        end
        spurious = 1'b0;
        check("no tag from spurious valid", 64'(tagCount), 64'(t0));
        check("no write from spurious valid", 64'(wrCount), 64'(w0));
        @(posedge clk);
        #1;

        // Reset after three returned words
        memLat = 2;
        t0 = tagCount;
        w0 = wrCount;
        issueMiss(16'h7654, -1);
        n = 0;
        while (wrCount < w0 + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("three words before reset", 64'(n < 100), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("outputs drop asynchronously", allOutputs(), 64'd0);
        expReqQ.delete();
        expWrQ.delete();
        expBusyQ.delete();
        pendQ.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("outputs after mid-fill reset", allOutputs(), 64'd0);
        check("no tag for aborted fill", 64'(tagCount), 64'(t0));
        check("words before abort", 64'(wrCount), 64'(w0 + 3));
        @(posedge clk);
        #1;
        issueMiss(16'h0020, BW + 2);
        waitDone(100, "fill after reset");

        repeat (3) @(posedge clk);
        check("leftover requests", 64'(expReqQ.size()), 64'd0);
        check("leftover writes", 64'(expWrQ.size()), 64'd0);
        check("leftover busy periods", 64'(expBusyQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
